// File: rtl/mpy_rr_sched.sv
// Round-robin scheduler in front of one shared iterative shift-add multiplier.
// Define MPY_RR_SCHED_SIGNED_EN for two's complement operands.
module mpy_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] in_a,
  input  logic [NREQ*W-1:0] in_b,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [2*W-1:0]    Product,
  output logic [IDW-1:0]    Product_Id,
  output logic              Product_Valid
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, win, id, ptr_nxt;
  logic           found;
  int             idx;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand, acc, fin, res;
  logic [W-1:0]   mplier, a_sel, b_sel, a_mag, b_mag;
  logic           last;

  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
  end

  assign a_sel = in_a[int'(win)*W +: W];
  assign b_sel = in_b[int'(win)*W +: W];
  assign last  = (cnt == CW'(W - 1));
  assign fin   = acc + (mplier[0] ? mcand : '0);

`ifdef MPY_RR_SCHED_SIGNED_EN
  logic neg;
  assign a_mag = a_sel[W-1] ? (~a_sel + W'(1)) : a_sel;
  assign b_mag = b_sel[W-1] ? (~b_sel + W'(1)) : b_sel;
  assign res   = neg ? (~fin + (2*W)'(1)) : fin;
`else
  assign a_mag = a_sel;
  assign b_mag = b_sel;
  assign res   = fin;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (found) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      ack           <= '0;
      busy          <= 1'b0;
      Product       <= '0;
      Product_Id    <= '0;
      Product_Valid <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      id            <= '0;
`ifdef MPY_RR_SCHED_SIGNED_EN
      neg           <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      ack           <= '0;
      Product_Valid <= 1'b0;
      unique case (state)
        IDLE: if (found) begin
          mcand  <= {{W{1'b0}}, a_mag};
          mplier <= b_mag;
          acc    <= '0;
          id     <= win;
          cnt    <= '0;
          ack    <= NREQ'(1) << win;
          ptr    <= ptr_nxt;
          busy   <= 1'b1;
`ifdef MPY_RR_SCHED_SIGNED_EN
          neg    <= a_sel[W-1] ^ b_sel[W-1];
`endif
        end
        RUN: begin
          acc    <= fin;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            Product       <= res;
            Product_Id    <= id;
            Product_Valid <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_rr_sched.sv
// Directed scoreboard bench for mpy_rr_sched.
// Honours MPY_RR_SCHED_SIGNED_EN to select the signed reference model.
module tb_mpy_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] in_a, in_b;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [2*W-1:0]    Product;
  logic [IDW-1:0]    Product_Id;
  logic              Product_Valid;

  mpy_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .in_a(in_a), .in_b(in_b),
    .ack(ack), .busy(busy), .Product(Product),
    .Product_Id(Product_Id), .Product_Valid(Product_Valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   ack_cyc = 0, pv_cyc = -1;
  logic pack = 1'b0, ppv = 1'b0;
  bit   chk_space = 1'b0;

  task automatic chk(string tag, logic [2*W-1:0] obs, logic [2*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] mul(logic [W-1:0] a, logic [W-1:0] b);
`ifdef MPY_RR_SCHED_SIGNED_EN
    logic [2*W-1:0] sa, sb2;
    sa  = {{W{a[W-1]}}, a};
    sb2 = {{W{b[W-1]}}, b};
    return sa * sb2;
`else
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
  endfunction

  task automatic step();
    logic [NREQ-1:0] eack;
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (ack !== '0) begin
      eack = (gq.size() != 0) ? (NREQ'(1) << gq[0]) : '0;
      chk("ack_grant", ack, eack);
      chk("ack_busy", busy, 1);
      chk("ack_not_twice", pack, 0);
      if (gq.size() != 0) void'(gq.pop_front());
      req     = req & ~ack;
      ack_cyc = cyc;
    end
    if (Product_Valid === 1'b1) begin
      chk("pv_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("product", Product, e.prod);
        chk("product_id", Product_Id, e.id);
        chk("latency", cyc - ack_cyc, W);
        chk("pv_not_twice", ppv, 0);
        chk("pv_busy_low", busy, 0);
        if (chk_space && pv_cyc >= 0) chk("spacing", cyc - pv_cyc, W + 1);
        pv_cyc = cyc;
      end
    end
    pack = |ack;
    ppv  = Product_Valid;
  endtask

  task automatic issue_x(int id, logic [W-1:0] a, logic [W-1:0] b,
                         logic [2*W-1:0] p);
    exp_t e;
    in_a[id*W +: W] = a;
    in_b[id*W +: W] = b;
    req[id] = 1'b1;
    gq.push_back(id);
    e.id   = IDW'(id);
    e.prod = p;
    sb.push_back(e);
  endtask

  task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b);
    issue_x(id, a, b, mul(a, b));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 1000 && (sb.size() != 0 || gq.size() != 0); n++) step();
    chk("timeout_pending", sb.size() + gq.size(), 0);
    sb.delete();
    gq.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_prod"}, Product, 0);
    chk({tag, "_id"}, Product_Id, 0);
    chk({tag, "_pv"}, Product_Valid, 0);
  endtask

  initial begin
    req  = '0;
    in_a = '0;
    in_b = '0;
    do_reset();
    chk_zero("reset");

    issue_x(0, 3, 5, 64'd15);
    wait_idle();
    step();
    chk("product_held", Product, 15);
    chk("pv_one_cycle", Product_Valid, 0);

    // ptr now 1: requester 3 wins over 0, then 0
    issue(3, 32'd11, 32'd13);
    issue(0, 32'd7, 32'd9);
    chk_space = 1'b1;
    pv_cyc    = -1;
    wait_idle();

    do_reset();
    issue_x(0, 1, 2, 64'd2);
    issue_x(1, 2, 2, 64'd4);
    issue_x(2, 3, 2, 64'd6);
    issue_x(3, 4, 2, 64'd8);
    pv_cyc = -1;
    wait_idle();
    chk_space = 1'b0;

`ifdef MPY_RR_SCHED_SIGNED_EN
    issue_x(2, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB);
    wait_idle();
    issue_x(1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_idle();
    issue_x(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
    wait_idle();
`else
    issue_x(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    wait_idle();
    issue_x(1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_idle();
`endif
    issue_x(3, 32'd0, 32'd123, 64'd0);
    wait_idle();

    // abort mid-run, pointer must restart at 0
    in_a[1*W +: W] = 32'd9;
    in_b[1*W +: W] = 32'd9;
    req[1] = 1'b1;
    gq.push_back(1);
    step();
    repeat (10) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_zero("abort");
    repeat (W + 2) step();
    chk("abort_no_pv", ppv, 0);
    issue(1, 32'd5, 32'd6);
    issue(2, 32'd100, 32'd200);
    wait_idle();

    // withdrawn request never granted
    issue(0, 32'd21, 32'd2);
    step();
    in_a[2*W +: W] = 32'd4;
    in_b[2*W +: W] = 32'd4;
    req[2] = 1'b1;
    repeat (3) step();
    req[2] = 1'b0;
    wait_idle();
    repeat (W + 4) step();
    chk("withdraw_no_ack", pack, 0);

    for (int r = 0; r < 6; r++) begin
      issue(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
